// File: rtl/control_unit_pkg.sv
// Shared BIP definitions: opcodes, datapath select encodings and control FSM state codes.
// Imported by the control unit, its decoder and the datapath.
package control_unit_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'd0;
  localparam logic [OPC_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'd7;

  localparam logic [1:0] SELA_MEM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  localparam logic SELB_MEM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/instruction_decoder.sv
// Purely combinational opcode decode into accumulator / data-memory control and datapath selects.
// Unlisted opcodes fall through to the all-zero NOP pattern.
module instruction_decoder
  import control_unit_pkg::*;
#(
  parameter int OPCODE_LENGTH = 5
) (
  input  logic [OPCODE_LENGTH-1:0] opcode,
  output logic                     wr_acc,
  output logic                     wr_ram,
  output logic                     rd_ram,
  output logic [1:0]               sel_a,
  output logic                     sel_b
);

  always_comb begin
    wr_acc = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    sel_a  = SELA_MEM;
    sel_b  = SELB_MEM;
    case (opcode)
      OPCODE_LENGTH'(OP_STO): begin
        wr_ram = 1'b1;
      end
      OPCODE_LENGTH'(OP_LD): begin
        wr_acc = 1'b1;
        rd_ram = 1'b1;
      end
      OPCODE_LENGTH'(OP_LDI): begin
        wr_acc = 1'b1;
        sel_a  = SELA_IMM;
      end
      OPCODE_LENGTH'(OP_ADD), OPCODE_LENGTH'(OP_SUB): begin
        wr_acc = 1'b1;
        rd_ram = 1'b1;
        sel_a  = SELA_ALU;
      end
      OPCODE_LENGTH'(OP_ADDI), OPCODE_LENGTH'(OP_SUBI): begin
        wr_acc = 1'b1;
        sel_a  = SELA_ALU;
        sel_b  = SELB_IMM;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// BIP control unit: IDLE/RUN/HALT sequencer, program counter and RUN cycle counter.
// Control outputs are decoded combinationally from the fetched word and gated to zero outside RUN.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int OPCODE_LENGTH      = 5,
  parameter int OPERANDO_LENGTH    = 11,
  parameter int INSTRUCTION_LENGTH = 16,
  parameter int COUNTER_LENGTH     = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [INSTRUCTION_LENGTH-1:0] i_instruction,
  output logic [OPERANDO_LENGTH-1:0]    o_pc,
  output logic [1:0]                    o_selA,
  output logic                          o_selB,
  output logic                          o_wrACC,
  output logic                          o_wrRAM,
  output logic                          o_rdRAM,
  output logic [OPCODE_LENGTH-1:0]      o_opcode,
  output logic [OPERANDO_LENGTH-1:0]    o_operando,
  output logic                          o_halt,
  output logic [COUNTER_LENGTH-1:0]     o_cycles,
  output logic [1:0]                    o_state
);

  state_t                      state_q, state_d;
  logic [OPERANDO_LENGTH-1:0]  pc_q, pc_d;
  logic [COUNTER_LENGTH-1:0]   cycles_q;

  logic [OPCODE_LENGTH-1:0]    opcode_f;
  logic [OPERANDO_LENGTH-1:0]  operand_f;
  logic                        running;
  logic                        is_hlt;

  logic                        dec_wr_acc;
  logic                        dec_wr_ram;
  logic                        dec_rd_ram;
  logic [1:0]                  dec_sel_a;
  logic                        dec_sel_b;

  assign opcode_f  = i_instruction[INSTRUCTION_LENGTH-1 -: OPCODE_LENGTH];
  assign operand_f = i_instruction[OPERANDO_LENGTH-1:0];
  assign running   = (state_q == ST_RUN);
  assign is_hlt    = (opcode_f == OPCODE_LENGTH'(OP_HLT));

  instruction_decoder #(
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_decoder (
    .opcode (opcode_f),
    .wr_acc (dec_wr_acc),
    .wr_ram (dec_wr_ram),
    .rd_ram (dec_rd_ram),
    .sel_a  (dec_sel_a),
    .sel_b  (dec_sel_b)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // The HLT cycle itself is counted; the counter sticks at all-ones.
      if (running && (cycles_q != '1)) begin
        cycles_q <= cycles_q + COUNTER_LENGTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (i_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // PC wraps naturally at the top of the address space.
        if (is_hlt) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_q + OPERANDO_LENGTH'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_comb begin
    o_wrACC    = 1'b0;
    o_wrRAM    = 1'b0;
    o_rdRAM    = 1'b0;
    o_selA     = SELA_MEM;
    o_selB     = SELB_MEM;
    o_opcode   = '0;
    o_operando = '0;
    if (running) begin
      o_wrACC    = dec_wr_acc;
      o_wrRAM    = dec_wr_ram;
      o_rdRAM    = dec_rd_ram;
      o_selA     = dec_sel_a;
      o_selB     = dec_sel_b;
      o_opcode   = opcode_f;
      o_operando = operand_f;
    end
  end

  assign o_pc     = pc_q;
  assign o_cycles = cycles_q;
  assign o_halt   = (state_q == ST_HALT);
  assign o_state  = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a behavioural program memory feeds i_instruction from o_pc.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic [10:0] pc;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        wr_acc;
  logic        wr_ram;
  logic        rd_ram;
  logic [4:0]  opcode;
  logic [10:0] operando;
  logic        halt;
  logic [15:0] cycles;
  logic [1:0]  state;

  logic [15:0] mem [0:2047];
  logic [5:0]  ctrl;

  int checks;
  int failures;

  assign instr = mem[pc];
  assign ctrl  = {wr_acc, wr_ram, rd_ram, sel_a, sel_b};

  control_unit dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .i_instruction (instr),
    .o_pc          (pc),
    .o_selA        (sel_a),
    .o_selB        (sel_b),
    .o_wrACC       (wr_acc),
    .o_wrRAM       (wr_ram),
    .o_rdRAM       (rd_ram),
    .o_opcode      (opcode),
    .o_operando    (operando),
    .o_halt        (halt),
    .o_cycles      (cycles),
    .o_state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) mem[i] = {5'd8, 11'd0};
  endtask

  // After return the DUT is in RUN and the first instruction is being presented.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_nop();
    mem[0] = {5'd2, 11'd7};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pc !== 11'd0 || cycles !== 16'd0 || halt !== 1'b0 || state !== 2'd0) begin
        failures++;
        $display("FAIL reset_idle_state k=%0d pc=%0d cycles=%0d halt=%b state=%0d expected 0/0/0/0", k, pc, cycles, halt, state);
      end
      checks++;
      if (ctrl !== 6'b000000 || opcode !== 5'd0 || operando !== 11'd0) begin
        failures++;
        $display("FAIL reset_idle_gating k=%0d ctrl=%b opcode=%0d operando=%0d expected 000000/0/0", k, ctrl, opcode, operando);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ldi_addi_hlt();
    logic [10:0] exp_pc [0:5];
    logic [15:0] exp_cyc [0:5];
    logic [5:0]  exp_ctrl [0:5];
    logic        exp_halt [0:5];
    exp_pc   = '{11'd0, 11'd1, 11'd2, 11'd2, 11'd2, 11'd2};
    exp_cyc  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
    exp_ctrl = '{6'b100010, 6'b100101, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    exp_halt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    fill_nop();
    mem[0] = {5'd3, 11'd5};
    mem[1] = {5'd5, 11'd3};
    mem[2] = {5'd0, 11'd0};
    do_reset();
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (pc !== exp_pc[k] || cycles !== exp_cyc[k] || halt !== exp_halt[k]) begin
        failures++;
        $display("FAIL prog_ldi step=%0d pc=%0d cycles=%0d halt=%b expected %0d/%0d/%b", k, pc, cycles, halt, exp_pc[k], exp_cyc[k], exp_halt[k]);
      end
      checks++;
      if (ctrl !== exp_ctrl[k]) begin
        failures++;
        $display("FAIL prog_ldi_ctrl step=%0d ctrl=%b expected %b", k, ctrl, exp_ctrl[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ld_sto();
    fill_nop();
    mem[0] = {5'd2, 11'd7};
    mem[1] = {5'd1, 11'd8};
    mem[2] = {5'd0, 11'd0};
    do_reset();
    pulse_start();
    checks++;
    if (ctrl !== 6'b101000 || operando !== 11'd7 || opcode !== 5'd2) begin
      failures++;
      $display("FAIL ld_cycle0 ctrl=%b operando=%0d opcode=%0d expected 101000/7/2", ctrl, operando, opcode);
    end
    @(negedge clk);
    checks++;
    if (ctrl !== 6'b010000 || operando !== 11'd8 || opcode !== 5'd1) begin
      failures++;
      $display("FAIL sto_cycle1 ctrl=%b operando=%0d opcode=%0d expected 010000/8/1", ctrl, operando, opcode);
    end
  endtask

  task automatic test_decode_alu();
    logic [15:0] prog [0:3];
    logic [5:0]  exp_ctrl [0:3];
    prog     = '{{5'd4, 11'd1}, {5'd6, 11'd2}, {5'd7, 11'd4}, {5'd5, 11'd9}};
    exp_ctrl = '{6'b101100, 6'b101100, 6'b100101, 6'b100101};
    fill_nop();
    for (int i = 0; i < 4; i++) mem[i] = prog[i];
    mem[4] = {5'd0, 11'd0};
    do_reset();
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ctrl !== exp_ctrl[k] || opcode !== prog[k][15:11] || operando !== prog[k][10:0]) begin
        failures++;
        $display("FAIL decode_alu step=%0d ctrl=%b opcode=%0d operando=%0d expected %b/%0d/%0d", k, ctrl, opcode, operando, exp_ctrl[k], prog[k][15:11], prog[k][10:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_nop_opcode();
    fill_nop();
    mem[0] = {5'd15, 11'h7FF};
    do_reset();
    pulse_start();
    checks++;
    if (ctrl !== 6'b000000 || opcode !== 5'd15) begin
      failures++;
      $display("FAIL nop15_ctrl ctrl=%b opcode=%0d expected 000000/15", ctrl, opcode);
    end
    @(negedge clk);
    checks++;
    if (pc !== 11'd1 || halt !== 1'b0) begin
      failures++;
      $display("FAIL nop15_advance pc=%0d halt=%b expected 1/0", pc, halt);
    end
  endtask

  task automatic test_pc_wrap();
    fill_nop();
    do_reset();
    pulse_start();
    repeat (2047) @(negedge clk);
    checks++;
    if (pc !== 11'd2047) begin
      failures++;
      $display("FAIL wrap_reach pc=%0d expected 2047", pc);
    end
    @(negedge clk);
    checks++;
    if (pc !== 11'd0 || state !== 2'd1 || halt !== 1'b0 || cycles !== 16'd2048) begin
      failures++;
      $display("FAIL wrap_pc pc=%0d state=%0d halt=%b cycles=%0d expected 0/1/0/2048", pc, state, halt, cycles);
    end
  endtask

  task automatic test_reset_mid_run();
    fill_nop();
    mem[4] = {5'd2, 11'd3};
    do_reset();
    pulse_start();
    repeat (4) @(negedge clk);
    checks++;
    if (pc !== 11'd4 || ctrl !== 6'b101000) begin
      failures++;
      $display("FAIL midrun_pre pc=%0d ctrl=%b expected 4/101000", pc, ctrl);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 11'd0 || cycles !== 16'd0 || ctrl !== 6'b000000 || state !== 2'd0 || opcode !== 5'd0) begin
      failures++;
      $display("FAIL midrun_async pc=%0d cycles=%0d ctrl=%b state=%0d opcode=%0d expected 0/0/000000/0/0", pc, cycles, ctrl, state, opcode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pc !== 11'd0 || cycles !== 16'd0 || state !== 2'd0) begin
      failures++;
      $display("FAIL midrun_no_resume pc=%0d cycles=%0d state=%0d expected 0/0/0", pc, cycles, state);
    end
    pulse_start();
    @(negedge clk);
    checks++;
    if (pc !== 11'd1 || cycles !== 16'd1) begin
      failures++;
      $display("FAIL midrun_restart pc=%0d cycles=%0d expected 1/1", pc, cycles);
    end
  endtask

  task automatic test_start_in_halt();
    fill_nop();
    mem[0] = {5'd8, 11'd0};
    mem[1] = {5'd0, 11'd5};
    do_reset();
    pulse_start();
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 11'd1 || cycles !== 16'd2 || halt !== 1'b1 || opcode !== 5'd0 || operando !== 11'd0) begin
      failures++;
      $display("FAIL halt_entry pc=%0d cycles=%0d halt=%b opcode=%0d operando=%0d expected 1/2/1/0/0", pc, cycles, halt, opcode, operando);
    end
    pulse_start();
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 11'd1 || cycles !== 16'd2 || halt !== 1'b1 || state !== 2'd2) begin
      failures++;
      $display("FAIL halt_start_ignored pc=%0d cycles=%0d halt=%b state=%0d expected 1/2/1/2", pc, cycles, halt, state);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    test_reset();
    test_ldi_addi_hlt();
    test_ld_sto();
    test_decode_alu();
    test_nop_opcode();
    test_pc_wrap();
    test_reset_mid_run();
    test_start_in_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
